// File: rtl/fb_write_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter_if
// Description : Bundle of the requester handshake, clear control and
//               framebuffer write-side signals used by fb_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_write_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    // Requester side (flattened, requester i at [i*W +: W])
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

    // Clear sequencer control
    logic                          clear_start;
    logic [DATA_WIDTH-1:0]         clear_value;
    logic                          clear_busy;

    // Framebuffer write side
    logic                          fb_rst_busy;
    logic                          fb_en_wr;
    logic [ADDR_WIDTH-1:0]         fb_addr_wr;
    logic [DATA_WIDTH-1:0]         fb_din;
    logic                          oob_err;

    // Clients / environment view
    modport master (
        output req_valid, req_addr, req_data, clear_start, clear_value, fb_rst_busy,
        input  req_ready, clear_busy, fb_en_wr, fb_addr_wr, fb_din, oob_err
    );

    // Arbiter view
    modport slave (
        input  req_valid, req_addr, req_data, clear_start, clear_value, fb_rst_busy,
        output req_ready, clear_busy, fb_en_wr, fb_addr_wr, fb_din, oob_err
    );
endinterface
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Round-robin arbiter sharing the framebuffer write port
//               between NUM_REQ pixel writers, plus a clear sequencer that
//               fills every pixel with a constant value.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 4,
    parameter int FRAME_HEIGHT = 3
) (
    input  logic               clk,
    input  logic               rst,
    fb_write_arbiter_if.slave  bus
);

    localparam int c_pixels_int = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int c_rr_w       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so the range compare works even when PIXELS == 2**ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0]   c_pixels    = (ADDR_WIDTH+1)'(c_pixels_int);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(c_pixels_int - 1);
    localparam logic [c_rr_w-1:0]     c_last_req  = c_rr_w'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_rr_w-1:0]       r_rr;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [DATA_WIDTH-1:0]   r_clr_val;
    logic                    r_en_wr;
    logic [ADDR_WIDTH-1:0]   r_addr_wr;
    logic [DATA_WIDTH-1:0]   r_din;
    logic                    r_clear_busy;
    logic                    r_oob_err;

    logic                    w_found;
    logic [c_rr_w-1:0]       w_grant_idx;
    logic                    w_arb_ok;
    logic                    w_xfer;
    logic [NUM_REQ-1:0]      w_ready;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_in_range;
    logic [c_rr_w-1:0]       w_rr_next;

    // Search for the first valid requester starting at the round-robin pointer
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!w_found && bus.req_valid[(int'(r_rr) + off) % NUM_REQ]) begin
                w_found     = 1'b1;
                w_grant_idx = c_rr_w'((int'(r_rr) + off) % NUM_REQ);
            end
        end
    end

    // Requests are only accepted while arbitrating, not being pre-empted by a
    // clear start, and not stalled by the framebuffer's own reset sweep
    assign w_arb_ok   = !rst && (r_state == ST_ARB) && !bus.clear_start && !bus.fb_rst_busy;
    assign w_xfer     = w_arb_ok && w_found;
    assign w_ready    = w_xfer ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_sel_addr = bus.req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data = bus.req_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_in_range = ({1'b0, w_sel_addr} < c_pixels);
    assign w_rr_next  = (w_grant_idx == c_last_req) ? '0 : (w_grant_idx + c_rr_w'(1));

    // Arbitration / clear FSM with all framebuffer-facing outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ARB;
            r_rr         <= '0;
            r_clr_cnt    <= '0;
            r_clr_val    <= '0;
            r_en_wr      <= 1'b0;
            r_addr_wr    <= '0;
            r_din        <= '0;
            r_clear_busy <= 1'b0;
            r_oob_err    <= 1'b0;
        end else begin
            r_en_wr      <= 1'b0;
            r_oob_err    <= 1'b0;
            r_clear_busy <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (bus.clear_start) begin
                        r_state      <= ST_CLEAR;
                        r_clr_cnt    <= '0;
                        r_clr_val    <= bus.clear_value;
                        r_clear_busy <= 1'b1;
                    end else if (w_xfer) begin
                        r_rr <= w_rr_next;
                        // Out-of-range writes are consumed but never reach the framebuffer
                        if (w_in_range) begin
                            r_en_wr   <= 1'b1;
                            r_addr_wr <= w_sel_addr;
                            r_din     <= w_sel_data;
                        end else begin
                            r_oob_err <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    // Busy stays high through the cycle the last fill write is visible
                    r_clear_busy <= 1'b1;
                    if (!bus.fb_rst_busy) begin
                        r_en_wr   <= 1'b1;
                        r_addr_wr <= r_clr_cnt;
                        r_din     <= r_clr_val;
                        if (r_clr_cnt == c_last_addr) begin
                            r_state   <= ST_ARB;
                            r_clr_cnt <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.fb_en_wr   = r_en_wr;
    assign bus.fb_addr_wr = r_addr_wr;
    assign bus.fb_din     = r_din;
    assign bus.clear_busy = r_clear_busy;
    assign bus.oob_err    = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Scoreboard bench for fb_write_arbiter with directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int FW      = 4;
    localparam int FH      = 3;
    localparam int PIXELS  = FW * FH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fb_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    fb_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    // Expected registered outputs for one cycle
    typedef struct {
        int cyc;
        bit en;
        int addr;
        int data;
        bit oob;
        bit busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model state
    int m_rr       = 0;
    bit m_clearing = 0;
    int m_cidx     = 0;
    int m_cval     = 0;

    // Shadow of the framebuffer as written by the DUT
    int mem[16];
    int wr_count[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the response, queue it, advance a clock
    task automatic step(input bit r, input bit [1:0] v, input int a0, input int a1,
                        input int d0, input int d1, input bit cs, input int cv,
                        input bit frb);
        exp_t e;
        int   a[2];
        int   d[2];
        int   exp_ready;
        int   g;
        rst              = r;
        bif.req_valid    = v;
        bif.req_addr     = {AW'(a1), AW'(a0)};
        bif.req_data     = {DW'(d1), DW'(d0)};
        bif.clear_start  = cs;
        bif.clear_value  = DW'(cv);
        bif.fb_rst_busy  = frb;
        #1;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        e = '{default: 0};
        e.cyc = cyc + 1;
        exp_ready = 0;
        if (r) begin
            m_rr = 0; m_clearing = 0; m_cidx = 0;
        end else if (m_clearing) begin
            e.busy = 1;
            if (!frb) begin
                e.en = 1; e.addr = m_cidx; e.data = m_cval;
                if (m_cidx == PIXELS - 1) m_clearing = 0;
                else m_cidx++;
            end
        end else if (cs) begin
            m_clearing = 1; m_cidx = 0; m_cval = cv; e.busy = 1;
        end else if (!frb) begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (g < 0 && v[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
            if (g >= 0) begin
                exp_ready = 1 << g;
                m_rr = (g + 1) % NUM_REQ;
                if (a[g] < PIXELS) begin
                    e.en = 1; e.addr = a[g]; e.data = d[g];
                end else begin
                    e.oob = 1;
                end
            end
        end
        check("req_ready", int'(bif.req_ready), exp_ready);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare registered outputs against the queued expectation
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                me = sb.pop_front();
                check("stale_expectation", 1, 0);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                me = sb.pop_front();
                check("fb_en_wr", int'(bif.fb_en_wr), int'(me.en));
                check("oob_err", int'(bif.oob_err), int'(me.oob));
                check("clear_busy", int'(bif.clear_busy), int'(me.busy));
                if (me.en) begin
                    check("fb_addr_wr", int'(bif.fb_addr_wr), me.addr);
                    check("fb_din", int'(bif.fb_din), me.data);
                end
            end
            if (bif.fb_en_wr === 1'b1) begin
                mem[bif.fb_addr_wr]      = int'(bif.fb_din);
                wr_count[bif.fb_addr_wr] = wr_count[bif.fb_addr_wr] + 1;
            end
        end
    end

    // Hard time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bif.req_valid   = '0;
        bif.req_addr    = '0;
        bif.req_data    = '0;
        bif.clear_start = 1'b0;
        bif.clear_value = '0;
        bif.fb_rst_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin mem[i] = 0; wr_count[i] = 0; end
        @(negedge clk);

        // Reset for two cycles, then both requesters valid
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("reset_addr", int'(bif.fb_addr_wr), 0);
        check("reset_din", int'(bif.fb_din), 0);

        // Both valid for four cycles: alternating grants
        step(0, 2'b11, 1, 2, 8'h11, 8'h22, 0, 0, 0);
        step(0, 2'b11, 3, 4, 8'h33, 8'h44, 0, 0, 0);
        step(0, 2'b11, 5, 6, 8'h55, 8'h66, 0, 0, 0);
        step(0, 2'b11, 7, 8, 8'h77, 8'h88, 0, 0, 0);
        idle(1);

        // Only requester 1
        step(0, 2'b10, 0, 5, 0, 8'hA5, 0, 0, 0);
        idle(1);

        // Clear with requester 0 waiting throughout
        step(0, 2'b01, 9, 0, 8'h99, 0, 1, 8'h3C, 0);
        for (int j = 0; j < 14; j++) step(0, 2'b01, 9, 0, 8'h99, 0, 0, 0, 0);
        idle(2);

        // Clear with a framebuffer-reset stall at address 6
        for (int i = 0; i < 16; i++) begin mem[i] = 0; wr_count[i] = 0; end
        step(0, 2'b00, 0, 0, 0, 0, 1, 8'h3C, 0);
        for (int j = 1; j <= 15; j++) step(0, 2'b00, 0, 0, 0, 0, 0, 0, (j >= 7 && j <= 9));
        idle(2);
        #1;
        for (int i = 0; i < PIXELS; i++) begin
            check("readback_pixel", mem[i], 8'h3C);
            check("write_once", wr_count[i], 1);
        end

        // Out-of-range request, then reset in the middle of a clear
        step(0, 2'b01, 12, 0, 8'hEE, 0, 0, 0, 0);
        idle(1);
        step(0, 2'b00, 0, 0, 0, 0, 1, 8'h5A, 0);
        idle(4);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 149) == 0),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 24) == 0),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 11) == 0));
        end
        idle(20);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
